// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous level and qualifies each level change with a tick-driven stability counter.
// Optional glitch counter is built only when INPUT_DEBOUNCER_GLITCH_CNT_EN is defined; otherwise glitch_count reads 0.
module input_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   GLITCH_W        = 8,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                async_in,
  input  logic                tick,
  output logic                data_out,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE_LO, PEND_HI, IDLE_HI, PEND_LO} state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // Bounce back to the held level always beats a pending final tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_LEVEL ? IDLE_HI : IDLE_LO;
      data_out <= RESET_LEVEL;
      busy     <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE_LO: if (sync_q) begin
          state <= PEND_HI;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        PEND_HI: begin
          if (!sync_q) begin
            state <= IDLE_LO;
            busy  <= 1'b0;
          end else if (tick) begin
            if (cnt == CNT_LAST) begin
              state    <= IDLE_HI;
              data_out <= 1'b1;
              busy     <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        IDLE_HI: if (!sync_q) begin
          state <= PEND_LO;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        PEND_LO: begin
          if (sync_q) begin
            state <= IDLE_HI;
            busy  <= 1'b0;
          end else if (tick) begin
            if (cnt == CNT_LAST) begin
              state    <= IDLE_LO;
              data_out <= 1'b0;
              busy     <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE_LO;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q;
  logic                bounce;

  assign bounce = ((state == PEND_HI) && !sync_q) || ((state == PEND_LO) && sync_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         glitch_q <= '0;
    else if (bounce && (glitch_q != '1)) glitch_q <= glitch_q + GLITCH_W'(1);
  end

  assign glitch_count = glitch_q;
`else
  assign glitch_count = '0;
`endif

endmodule
